// File: rtl/fifo_rr_write_ctrl_if.sv
// Bus bundle between the shared-queue controller, its producers/consumer and the FIFO memory.
interface fifo_rr_write_ctrl_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned DEPTH    = 16
);
  localparam int unsigned ADDRSIZE = $clog2(DEPTH);
  localparam int unsigned IDW      = $clog2(NUM_REQ);

  logic                         flush;
  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATASIZE-1:0]  req_data;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         rd_req;
  logic                         rd_valid;
  logic [IDW-1:0]               rd_src;
  logic                         mem_wr_en;
  logic [ADDRSIZE-1:0]          mem_wr_addr;
  logic [DATASIZE-1:0]          mem_data_in;
  logic                         mem_rd_en;
  logic [ADDRSIZE-1:0]          mem_rd_addr;
  logic                         full;
  logic                         empty;
  logic [ADDRSIZE:0]            count;

  // Controller side
  modport slave (
    input  flush, req_valid, req_data, rd_req,
    output req_ready, rd_valid, rd_src,
    output mem_wr_en, mem_wr_addr, mem_data_in, mem_rd_en, mem_rd_addr,
    output full, empty, count
  );

  // Producer / consumer / memory side
  modport master (
    output flush, req_valid, req_data, rd_req,
    input  req_ready, rd_valid, rd_src,
    input  mem_wr_en, mem_wr_addr, mem_data_in, mem_rd_en, mem_rd_addr,
    input  full, empty, count
  );
endinterface

// File: rtl/fifo_rr_write_ctrl.sv
// Shared-queue controller: round-robin write arbitration over NUM_REQ producers,
// pointer/status generation for a DEPTH-entry FIFO memory, and a source-ID sidecar.
module fifo_rr_write_ctrl #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_rr_write_ctrl_if.slave   bus
);
  localparam int unsigned ADDRSIZE = $clog2(DEPTH);
  localparam int unsigned IDW      = $clog2(NUM_REQ);
  localparam int unsigned PTRW     = ADDRSIZE + 1;

  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]  rd_src_q, rd_src_d;
  logic            rd_valid_q, rd_valid_d;
  logic [IDW-1:0]  id_mem_q [DEPTH];

  logic            full_c;
  logic            empty_c;
  logic [PTRW-1:0] count_c;
  logic            gnt_found;
  logic [IDW-1:0]  gnt_idx;
  logic            push;
  logic            pop;

  // Queue status from the registered pointers (start-of-cycle view)
  always_comb begin
    full_c  = (wr_ptr_q[ADDRSIZE] != rd_ptr_q[ADDRSIZE]) &&
              (wr_ptr_q[ADDRSIZE-1:0] == rd_ptr_q[ADDRSIZE-1:0]);
    empty_c = (wr_ptr_q == rd_ptr_q);
    count_c = wr_ptr_q - rd_ptr_q;
  end

  // Round-robin search: first valid requester at or above rr_ptr, wrapping
  always_comb begin : arb_p
    int unsigned idx;
    idx       = 0;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_found && bus.req_valid[IDW'(idx)]) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(idx);
      end
    end
  end

  // Transfer qualifiers: flush and reset block both sides, full blocks push, empty blocks pop
  always_comb begin
    push = !rst && gnt_found && !full_c && !bus.flush;
    pop  = !rst && bus.rd_req && !empty_c && !bus.flush;
  end

  // Producer handshake, memory controls and status outputs
  always_comb begin
    bus.req_ready          = '0;
    if (push) bus.req_ready[gnt_idx] = 1'b1;
    bus.mem_wr_en          = push;
    bus.mem_wr_addr        = wr_ptr_q[ADDRSIZE-1:0];
    bus.mem_data_in        = bus.req_data[32'(gnt_idx)*DATASIZE +: DATASIZE];
    bus.mem_rd_en          = pop;
    bus.mem_rd_addr        = rd_ptr_q[ADDRSIZE-1:0];
    bus.full               = full_c;
    bus.empty              = empty_c;
    bus.count              = count_c;
    bus.rd_valid           = rd_valid_q;
    bus.rd_src             = rd_src_q;
  end

  // Next-state: pointer advance, arbiter rotation, read-side tracking, flush override
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rr_ptr_d   = rr_ptr_q;
    rd_src_d   = rd_src_q;
    rd_valid_d = pop;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTRW'(1);
      rr_ptr_d = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTRW'(1);
      rd_src_d = id_mem_q[rd_ptr_q[ADDRSIZE-1:0]];
    end
    if (bus.flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      rd_valid_d = 1'b0;
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      rr_ptr_q   <= '0;
      rd_src_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rr_ptr_q   <= rr_ptr_d;
      rd_src_q   <= rd_src_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Source-ID sidecar; contents are meaningful only between the pointers, so no reset
  always_ff @(posedge clk) begin
    if (push) id_mem_q[wr_ptr_q[ADDRSIZE-1:0]] <= gnt_idx;
  end
endmodule
